// File: rtl/npc_mem_pkg.sv
// npc_mem_pkg: shared encodings for the load/store memory responder, plus the
// simulation-side backing store behind the v_pmem_read / v_pmem_write calls.
package npc_mem_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Fibonacci taps 16,14,13,11 in a shift-left register (bits 15,13,12,10).
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Small word-addressed memory; addresses wrap onto PMEM_WORDS words.
    localparam int PMEM_WORDS = 1024;

    logic [31:0] pmem [PMEM_WORDS];
    int unsigned pmem_wr_calls = 0;
    logic [31:0] pmem_last_waddr = '0;
    logic [31:0] pmem_last_wdata = '0;
    logic [3:0]  pmem_last_wmask = '0;

    function automatic logic [31:0] v_pmem_read(input logic [31:0] raddr,
                                                input int len);
        logic [9:0] idx;
        idx = 10'(raddr >> 2);
        if (len == 4)
            return pmem[idx];
        return '0;
    endfunction

    function automatic void v_pmem_write(input logic [31:0] waddr,
                                         input logic [31:0] wdata,
                                         input logic [3:0]  wmask);
        logic [9:0] idx;
        idx = 10'(waddr >> 2);
        for (int i = 0; i < 4; i++)
            if (wmask[i])
                pmem[idx][8*i +: 8] = wdata[8*i +: 8];
        pmem_wr_calls   = pmem_wr_calls + 1;
        pmem_last_waddr = waddr;
        pmem_last_wdata = wdata;
        pmem_last_wmask = wmask;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte-lane steering for the memory responder.
// Ports: off/size/sgn describe the access; wdata/rword are right-aligned store
// data and the raw memory word; outputs misalign, wmask, wdata_sh, rdata_ext.
module mem_lane_align
    import npc_mem_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        sgn,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic        misalign,
    output logic [3:0]  wmask,
    output logic [31:0] wdata_sh,
    output logic [31:0] rdata_ext
);

    logic [31:0] lane;

    always_comb begin
        misalign  = 1'b0;
        wmask     = 4'b0000;
        lane      = rword >> {off, 3'b000};
        wdata_sh  = wdata << {off, 3'b000};
        rdata_ext = '0;
        unique case (size)
            SZ_B: begin
                wmask     = 4'b0001 << off;
                rdata_ext = {{24{sgn & lane[7]}}, lane[7:0]};
            end
            SZ_H: begin
                misalign  = off[0];
                wmask     = 4'b0011 << off;
                rdata_ext = {{16{sgn & lane[15]}}, lane[15:0]};
            end
            SZ_W: begin
                misalign  = |off;
                wmask     = 4'b1111;
                rdata_ext = rword;
            end
            default: misalign = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: fixed-latency memory responder on valid/ready channels.
// Ports: clk, reset (sync, active-high); req_* request channel; resp_* response
// channel. Define MEM_RESP_RAND_DELAY_EN to add 0..3 cycles of LFSR delay.
module mem_responder
    import npc_mem_pkg::*;
#(
    parameter int          LATENCY    = 1,
    parameter logic [15:0] RESET_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_lat
        $error("mem_responder: LATENCY out of range 1..15");
    end
    if (RESET_SEED == 16'h0) begin : g_bad_seed
        $error("mem_responder: RESET_SEED must be nonzero");
    end

    localparam logic [4:0] CNT_INIT = 5'(LATENCY - 1);

    state_t      state;
    logic [4:0]  cnt;
    logic [4:0]  extra;
    logic        c_wen;
    logic [31:0] c_addr;
    logic [1:0]  c_size;
    logic        c_sgn;
    logic [31:0] c_wdata;
    // Raw memory word of a completed load; zero otherwise, so the lane
    // extension below yields 0 for stores, errors and idle.
    logic [31:0] raw_q;

    logic        misalign;
    logic [3:0]  wmask;
    logic [31:0] wdata_sh;

`ifdef MEM_RESP_RAND_DELAY_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk) begin
        if (reset)
            lfsr <= RESET_SEED;
        else
            lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
    end

    assign extra = {3'b000, lfsr[1:0]};
`else
    assign extra = 5'd0;
`endif

    mem_lane_align u_align (
        .off      (c_addr[1:0]),
        .size     (c_size),
        .sgn      (c_sgn),
        .wdata    (c_wdata),
        .rword    (raw_q),
        .misalign (misalign),
        .wmask    (wmask),
        .wdata_sh (wdata_sh),
        .rdata_ext(resp_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            raw_q      <= '0;
            c_wen      <= 1'b0;
            c_addr     <= '0;
            c_size     <= SZ_B;
            c_sgn      <= 1'b0;
            c_wdata    <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        c_wen     <= req_wen;
                        c_addr    <= req_addr;
                        c_size    <= req_size;
                        c_sgn     <= req_signed;
                        c_wdata   <= req_wdata;
                        cnt       <= CNT_INIT + extra;
                        req_ready <= 1'b0;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt != 5'd0) begin
                        cnt <= cnt - 5'd1;
                    end else begin
                        resp_valid <= 1'b1;
                        resp_err   <= misalign;
                        state      <= S_RESP;
                        if (!misalign) begin
                            if (c_wen)
                                v_pmem_write({c_addr[31:2], 2'b00},
                                             wdata_sh, wmask);
                            else
                                raw_q <= v_pmem_read({c_addr[31:2], 2'b00}, 4);
                        end
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        raw_q      <= '0;
                        req_ready  <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
